// File: rtl/iter_cipher_core.sv
// iter_cipher_core
// Iterative toy block cipher: one key-mixing round per clock.
//   state' = rotl1(state) ^ rk',  rk' = rotl8(rk) ^ zext(ctr)
// Round count comes from key_len at key load: 0->10, 1->12, 2->14 (3 is illegal).
//
// Ports
//   clk, rst        clock, synchronous active-high reset
//   key_len[1:0]    round mode, sampled with key_load
//   key             key value, captured on legal key_load in IDLE
//   key_load        key capture request
//   start           block request (accepted only when ready)
//   block_in        plaintext, sampled on accepted start
//   zeroize         wipe every piece of sensitive state
//   block_ack       consumer takes block_out (only meaningful in DONE)
//   ready           IDLE and a legal key is held
//   key_valid       a legal key is held
//   block_out       result, zero unless block_valid
//   block_valid     result held until acknowledged
//   err             one-cycle pulse on a rejected request
module iter_cipher_core #(
  parameter int DATA_W     = 128,
  parameter int MAX_ROUNDS = 14
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        key_len,
  input  logic [DATA_W-1:0] key,
  input  logic              key_load,
  input  logic              start,
  input  logic [DATA_W-1:0] block_in,
  input  logic              zeroize,
  input  logic              block_ack,
  output logic              ready,
  output logic              key_valid,
  output logic [DATA_W-1:0] block_out,
  output logic              block_valid,
  output logic              err
);

  // One spare count so ctr can step past N on the last round without wrapping.
  localparam int CW = $clog2(MAX_ROUNDS + 2);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    DONE  = 2'd2
  } fsm_t;

  fsm_t              fsm;
  logic [DATA_W-1:0] key_q;
  logic [DATA_W-1:0] st_q;
  logic [DATA_W-1:0] rk_q;
  logic [CW-1:0]     n_q;
  logic [CW-1:0]     ctr_q;

  logic [DATA_W-1:0] rk_nxt;
  logic [DATA_W-1:0] st_nxt;
  logic [CW-1:0]     n_sel;

  always_comb begin
    rk_nxt = {rk_q[DATA_W-9:0], rk_q[DATA_W-1:DATA_W-8]} ^ DATA_W'(ctr_q);
    st_nxt = {st_q[DATA_W-2:0], st_q[DATA_W-1]} ^ rk_nxt;
  end

  always_comb begin
    case (key_len)
      2'd0:    n_sel = CW'(10);
      2'd1:    n_sel = CW'(12);
      default: n_sel = CW'(14);
    endcase
  end

  assign ready     = (fsm == IDLE) && key_valid;
  // Mid-round state never leaks: the output is gated by the valid flag.
  assign block_out = block_valid ? st_q : '0;

  always_ff @(posedge clk) begin
    if (rst || zeroize) begin
      fsm         <= IDLE;
      key_q       <= '0;
      st_q        <= '0;
      rk_q        <= '0;
      n_q         <= '0;
      ctr_q       <= '0;
      key_valid   <= 1'b0;
      block_valid <= 1'b0;
      err         <= 1'b0;
    end else begin
      err <= 1'b0;
      case (fsm)
        IDLE: begin
          // key_load outranks start; a start alongside it is dropped silently.
          if (key_load) begin
            if (key_len != 2'd3) begin
              key_q     <= key;
              n_q       <= n_sel;
              key_valid <= 1'b1;
            end else begin
              key_q     <= '0;
              n_q       <= '0;
              key_valid <= 1'b0;
              err       <= 1'b1;
            end
          end else if (start) begin
            if (key_valid) begin
              st_q  <= block_in ^ key_q;
              rk_q  <= key_q;
              ctr_q <= CW'(1);
              fsm   <= ROUND;
            end else begin
              err <= 1'b1;
            end
          end
        end

        ROUND: begin
          st_q  <= st_nxt;
          rk_q  <= rk_nxt;
          ctr_q <= ctr_q + CW'(1);
          if (ctr_q == n_q) begin
            fsm         <= DONE;
            block_valid <= 1'b1;
          end
          if (start || key_load) err <= 1'b1;
        end

        DONE: begin
          if (start || key_load) err <= 1'b1;
          if (block_ack) begin
            st_q        <= '0;
            rk_q        <= '0;
            ctr_q       <= '0;
            block_valid <= 1'b0;
            fsm         <= IDLE;
          end
        end

        default: fsm <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_iter_cipher_core.sv
module tb_iter_cipher_core;

  logic         clk = 1'b0;
  logic         rst, key_load, start, zeroize, block_ack;
  logic [1:0]   key_len;
  logic [127:0] key, block_in;

  logic         ready, key_valid, block_valid, err;
  logic [127:0] block_out;
  logic         ready16, key_valid16, block_valid16, err16;
  logic [15:0]  block_out16;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  iter_cipher_core #(.DATA_W(128), .MAX_ROUNDS(14)) u_dut (
    .clk(clk), .rst(rst), .key_len(key_len), .key(key), .key_load(key_load),
    .start(start), .block_in(block_in), .zeroize(zeroize), .block_ack(block_ack),
    .ready(ready), .key_valid(key_valid), .block_out(block_out),
    .block_valid(block_valid), .err(err)
  );

  iter_cipher_core #(.DATA_W(16), .MAX_ROUNDS(14)) u_dut16 (
    .clk(clk), .rst(rst), .key_len(key_len), .key(key[15:0]), .key_load(key_load),
    .start(start), .block_in(block_in[15:0]), .zeroize(zeroize), .block_ack(block_ack),
    .ready(ready16), .key_valid(key_valid16), .block_out(block_out16),
    .block_valid(block_valid16), .err(err16)
  );

  // ---------------- reference model ----------------
  function automatic logic [127:0] msk(int w);
    logic [127:0] one;
    one = 128'd1;
    return (w >= 128) ? '1 : ((one << w) - one);
  endfunction

  function automatic logic [127:0] rotl(logic [127:0] x, int k, int w);
    return ((x << k) | (x >> (w - k))) & msk(w);
  endfunction

  // Straight from the round rule: whitening, then N rounds of the rk/state update.
  function automatic logic [127:0] model(logic [127:0] blk, logic [127:0] k, int n, int w);
    logic [127:0] s, r;
    s = (blk ^ k) & msk(w);
    r = k & msk(w);
    for (int c = 1; c <= n; c++) begin
      r = (rotl(r, 8, w) ^ 128'(c)) & msk(w);
      s = (rotl(s, 1, w) ^ r) & msk(w);
    end
    return s;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_key(input logic [1:0] kl, input logic [127:0] k);
    key_len  = kl;
    key      = k;
    key_load = 1'b1;
    tick();
    key_load = 1'b0;
  endtask

  // Start a block and wait for block_valid; lat counts cycles from the start edge.
  task automatic run_block(input logic [127:0] blk, output int lat, output logic rdy_after,
                           output int leak);
    block_in = blk;
    start    = 1'b1;
    tick();
    start     = 1'b0;
    rdy_after = ready;
    lat       = 1;
    leak      = 0;
    while (!block_valid && lat < 40) begin
      if (block_out !== 128'd0 || block_out16 !== 16'd0) leak++;
      tick();
      lat++;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1; key_load = 0; start = 0; zeroize = 0; block_ack = 0;
    key_len = 0; key = '0; block_in = '0;
    tick(); tick();
    rst = 1'b0;
    n_tests++;
    if ({ready, key_valid, block_valid, err} !== 4'b0000 || block_out !== 128'd0) begin
      n_fail++;
      $display("FAIL reset: rdy/kv/bv/err=%b out=%h, required 0000 and 0",
               {ready, key_valid, block_valid, err}, block_out);
    end
    n_tests++;
    if ({ready16, key_valid16, block_valid16, err16} !== 4'b0000 || block_out16 !== 16'd0) begin
      n_fail++;
      $display("FAIL reset16: rdy/kv/bv/err=%b out=%h, required 0000 and 0",
               {ready16, key_valid16, block_valid16, err16}, block_out16);
    end
  endtask

  task automatic test_rounds(input int kl);
    logic [127:0] k, blk, exp128, exp16;
    int lat, leak, n;
    logic rdy_after;
    n   = 10 + 2 * kl;
    k   = rnd128();
    blk = rnd128();
    load_key(2'(kl), k);
    n_tests++;
    if (key_valid !== 1'b1 || err !== 1'b0 || key_valid16 !== 1'b1) begin
      n_fail++;
      $display("FAIL rounds_keyload kl=%0d: kv=%b kv16=%b err=%b, required kv=1 err=0",
               kl, key_valid, key_valid16, err);
    end
    tick();
    run_block(blk, lat, rdy_after, leak);
    exp128 = model(blk, k, n, 128);
    exp16  = model(blk, k, n, 16);
    n_tests++;
    if (rdy_after !== 1'b0) begin
      n_fail++;
      $display("FAIL rounds_ready_drop kl=%0d: ready=%b, required 0", kl, rdy_after);
    end
    n_tests++;
    if (lat != n + 1 || block_valid16 !== 1'b1) begin
      n_fail++;
      $display("FAIL rounds_latency kl=%0d: got %0d (bv16=%b), required %0d", kl, lat,
               block_valid16, n + 1);
    end
    n_tests++;
    if (block_out !== exp128) begin
      n_fail++;
      $display("FAIL rounds_out128 kl=%0d: got %h, required %h", kl, block_out, exp128);
    end
    n_tests++;
    if (block_out16 !== exp16[15:0]) begin
      n_fail++;
      $display("FAIL rounds_out16 kl=%0d: got %h, required %h", kl, block_out16, exp16[15:0]);
    end
    n_tests++;
    if (leak != 0) begin
      n_fail++;
      $display("FAIL rounds_leak kl=%0d: %0d cycles nonzero out, required 0", kl, leak);
    end
    block_ack = 1'b1;
    tick();
    block_ack = 1'b0;
    n_tests++;
    if (block_valid !== 1'b0 || block_out !== 128'd0 || ready !== 1'b1 || key_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL rounds_ack kl=%0d: bv=%b out=%h rdy=%b kv=%b, required 0,0,1,1",
               kl, block_valid, block_out, ready, key_valid);
    end
  endtask

  task automatic test_hold_ack();
    logic [127:0] k, blk, exp128;
    int lat, leak;
    logic rdy_after;
    k   = rnd128();
    blk = rnd128();
    load_key(2'd2, k);
    run_block(blk, lat, rdy_after, leak);
    exp128 = model(blk, k, 14, 128);
    for (int i = 0; i < 20; i++) begin
      tick();
      n_tests++;
      if (block_valid !== 1'b1 || block_out !== exp128) begin
        n_fail++;
        $display("FAIL hold cycle %0d: bv=%b out=%h, required 1 and %h", i, block_valid,
                 block_out, exp128);
      end
    end
    block_ack = 1'b1;
    tick();
    block_ack = 1'b0;
    n_tests++;
    if (block_out !== 128'd0 || ready !== 1'b1 || block_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL hold_ack: out=%h rdy=%b bv=%b, required 0,1,0", block_out, ready, block_valid);
    end
  endtask

  task automatic test_illegal_key();
    int bad;
    load_key(2'd3, rnd128());
    n_tests++;
    if (err !== 1'b1 || key_valid !== 1'b0 || err16 !== 1'b1) begin
      n_fail++;
      $display("FAIL illegal_key: err=%b err16=%b kv=%b, required err=1 kv=0", err, err16, key_valid);
    end
    tick();
    n_tests++;
    if (err !== 1'b0) begin
      n_fail++;
      $display("FAIL illegal_err_width: err=%b, required 0", err);
    end
    start    = 1'b1;
    block_in = rnd128();
    tick();
    start = 1'b0;
    n_tests++;
    if (err !== 1'b1) begin
      n_fail++;
      $display("FAIL illegal_start_err: err=%b, required 1", err);
    end
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (block_valid !== 1'b0 || ready !== 1'b0) bad++;
    end
    n_tests++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL illegal_no_round: %0d bad cycles, required 0", bad);
    end
    // key_load and start together: key wins, start dropped, no error
    key_len  = 2'd0;
    key      = rnd128();
    key_load = 1'b1;
    start    = 1'b1;
    tick();
    key_load = 1'b0;
    start    = 1'b0;
    n_tests++;
    if (err !== 1'b0 || ready !== 1'b1 || key_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL keyload_vs_start: err=%b rdy=%b kv=%b, required 0,1,1", err, ready, key_valid);
    end
  endtask

  task automatic test_zeroize();
    int bad;
    load_key(2'd0, rnd128());
    tick();
    block_in = rnd128();
    start    = 1'b1;
    tick();               // first ROUND cycle, ctr=1
    start = 1'b0;
    repeat (4) tick();    // now ctr=5
    zeroize = 1'b1;
    tick();
    zeroize = 1'b0;
    n_tests++;
    if (key_valid !== 1'b0 || block_out !== 128'd0 || block_valid !== 1'b0 || err !== 1'b0 ||
        ready !== 1'b0) begin
      n_fail++;
      $display("FAIL zeroize: kv=%b out=%h bv=%b err=%b rdy=%b, required all 0",
               key_valid, block_out, block_valid, err, ready);
    end
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (block_valid !== 1'b0 || block_valid16 !== 1'b0) bad++;
    end
    n_tests++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL zeroize_no_result: %0d cycles with bv, required 0", bad);
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    n_tests++;
    if (err !== 1'b1) begin
      n_fail++;
      $display("FAIL zeroize_start_err: err=%b, required 1", err);
    end
  endtask

  task automatic test_back_to_back();
    logic [127:0] k, blk, exp128, held;
    int lat, leak;
    logic got_err, rdy_after;
    k   = rnd128();
    blk = rnd128();
    exp128 = model(blk, k, 12, 128);
    load_key(2'd1, k);
    block_in = blk;
    start    = 1'b1;
    tick();
    start   = 1'b0;
    lat     = 1;
    got_err = 1'b0;
    while (!block_valid && lat < 40) begin
      if (lat == 3) start = 1'b1;
      tick();
      start = 1'b0;
      lat++;
      if (lat == 4) got_err = err;
    end
    n_tests++;
    if (got_err !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_round_start_err: err=%b, required 1", got_err);
    end
    n_tests++;
    if (lat != 13 || block_out !== exp128) begin
      n_fail++;
      $display("FAIL b2b_result: lat=%0d out=%h, required 13 and %h", lat, block_out, exp128);
    end
    held     = block_out;
    key_len  = 2'd0;
    key      = rnd128();
    key_load = 1'b1;
    tick();
    key_load = 1'b0;
    n_tests++;
    if (err !== 1'b1 || block_valid !== 1'b1 || block_out !== held) begin
      n_fail++;
      $display("FAIL b2b_done_keyload: err=%b bv=%b out=%h, required 1,1,%h", err, block_valid,
               block_out, held);
    end
    block_ack = 1'b1;
    tick();
    block_ack = 1'b0;
    // the rejected key_load must not have replaced the key or round count
    run_block(blk, lat, rdy_after, leak);
    n_tests++;
    if (lat != 13 || block_out !== exp128) begin
      n_fail++;
      $display("FAIL b2b_key_retained: lat=%0d out=%h, required 13 and %h", lat, block_out, exp128);
    end
    block_ack = 1'b1;
    tick();
    block_ack = 1'b0;
  endtask

  task automatic test_rst_abort();
    int bad;
    load_key(2'd2, rnd128());
    block_in = rnd128();
    start    = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_tests++;
    if ({ready, key_valid, block_valid, err} !== 4'b0000 || block_out !== 128'd0) begin
      n_fail++;
      $display("FAIL rst_abort: rdy/kv/bv/err=%b out=%h, required 0000 and 0",
               {ready, key_valid, block_valid, err}, block_out);
    end
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (block_valid !== 1'b0) bad++;
    end
    n_tests++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL rst_abort_no_result: %0d cycles with bv, required 0", bad);
    end
  endtask

  initial begin
    test_reset();
    test_rounds(0);
    test_rounds(1);
    test_rounds(2);
    for (int i = 0; i < 5; i++) test_rounds(int'($urandom_range(0, 2)));
    test_hold_ack();
    test_illegal_key();
    test_zeroize();
    test_back_to_back();
    test_rst_abort();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
